// File: rtl/i_cache_assoc_if.sv
// Fetch-side lookup bus and single-beat refill channel of the set-associative instruction cache.
interface i_cache_assoc_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_READ   = 2,
    parameter int LINE_SIZE  = 2
);
    logic [NUM_READ-1:0][ADDR_WIDTH-1:0] read_addr;
    logic [NUM_READ-1:0]                 read_addr_valid;
    logic                                ext_stall;
    logic                                ext_flush;
    logic                                invalidate_all;
    logic [NUM_READ-1:0][31:0]           read_instr;
    logic [NUM_READ-1:0]                 valid_read;
    logic [NUM_READ-1:0]                 miss;
    logic                                int_stall;
    logic                                mem_req_valid;
    logic [ADDR_WIDTH-1:0]               mem_req_addr;
    logic                                mem_req_ready;
    logic                                mem_resp_valid;
    logic [32*LINE_SIZE-1:0]             mem_resp_data;

    modport slave (
        input  read_addr, read_addr_valid, ext_stall, ext_flush, invalidate_all,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output read_instr, valid_read, miss, int_stall, mem_req_valid, mem_req_addr
    );

    modport master (
        output read_addr, read_addr_valid, ext_stall, ext_flush, invalidate_all,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  read_instr, valid_read, miss, int_stall, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/i_cache_assoc.sv
// Set-associative multi-port instruction cache: NUM_READ lookups per cycle, one shared refill FSM,
// round-robin replacement and a set-by-set sweep for bulk invalidation.
module i_cache_assoc #(
    parameter int NUM_SETS   = 256,
    parameter int WAYS       = 2,
    parameter int LINE_SIZE  = 2,
    parameter int NUM_READ   = 2,
    parameter int ADDR_WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    i_cache_assoc_if.slave bus
);
    localparam int OFF_W   = $clog2(LINE_SIZE);
    localparam int IDX_W   = $clog2(NUM_SETS);
    localparam int WA_W    = ADDR_WIDTH - 2;
    localparam int LINE_AW = WA_W - OFF_W;
    localparam int TAG_W   = LINE_AW - IDX_W;
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_W  = 32 * LINE_SIZE;

    typedef enum logic [2:0] {INVAL, IDLE, REQ, WAIT, DRAIN, FILL} state_t;

    function automatic logic [OFF_W-1:0] off_of(input logic [WA_W-1:0] wa);
        return wa[OFF_W-1:0];
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [WA_W-1:0] wa);
        return wa[OFF_W +: IDX_W];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [WA_W-1:0] wa);
        return wa[WA_W-1 -: TAG_W];
    endfunction

    logic [NUM_SETS-1:0] valid_q [WAYS];
    logic [TAG_W-1:0]    tag_q   [WAYS][NUM_SETS];
    logic [LINE_W-1:0]   data_q  [WAYS][NUM_SETS];
    logic [WAY_W-1:0]    rr_q    [NUM_SETS];

    state_t              state;
    logic [IDX_W-1:0]    sweep_cnt;
    logic                inv_pend;
    logic [LINE_AW-1:0]  req_line;
    logic [LINE_W-1:0]   fill_data;

    logic [NUM_READ-1:0][WA_W-1:0]    addr_p0;
    logic [NUM_READ-1:0]              vld_p0;
    logic [NUM_READ-1:0][LINE_AW-1:0] line_p1;
    logic [NUM_READ-1:0]              vld_p1;
    logic [NUM_READ-1:0]              hit_p1;
    logic [NUM_READ-1:0][31:0]        word_p1;
    logic [NUM_READ-1:0]              vld_p2;
    logic [NUM_READ-1:0]              miss_p2;
    logic [NUM_READ-1:0][31:0]        instr_p2;

    logic [NUM_READ-1:0]       hit_c;
    logic [NUM_READ-1:0][31:0] word_c;
    logic [NUM_READ-1:0]       miss_vec;
    logic [LINE_AW-1:0]        miss_line;
    logic                      miss_det;
    logic                      int_stall;
    logic [IDX_W-1:0]          ridx;
    logic [WAY_W-1:0]          victim;
    logic [WAY_W-1:0]          rr_next;

    assign ridx      = req_line[0 +: IDX_W];
    assign miss_vec  = vld_p1 & ~hit_p1;
    assign miss_det  = (state == IDLE) && !bus.ext_stall && !bus.ext_flush && (|miss_vec);
    assign int_stall = reset || (state != IDLE) || miss_det;

    assign bus.int_stall     = int_stall;
    assign bus.mem_req_valid = (state == REQ);
    assign bus.mem_req_addr  = {req_line, {(OFF_W + 2){1'b0}}};
    assign bus.valid_read    = vld_p2;
    assign bus.miss          = miss_p2;
    assign bus.read_instr    = instr_p2;

    // Stage p0 -> p1: tag compare and word select across all ways; lowest matching way wins
    always_comb begin
        for (int p = 0; p < NUM_READ; p++) begin
            hit_c[p]  = 1'b0;
            word_c[p] = '0;
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (valid_q[w][idx_of(addr_p0[p])] &&
                    tag_q[w][idx_of(addr_p0[p])] == tag_of(addr_p0[p])) begin
                    hit_c[p]  = 1'b1;
                    word_c[p] = data_q[w][idx_of(addr_p0[p])][32*off_of(addr_p0[p]) +: 32];
                end
            end
        end
    end

    always_comb begin
        miss_line = '0;
        for (int p = NUM_READ - 1; p >= 0; p--)
            if (miss_vec[p]) miss_line = line_p1[p];
    end

    always_comb begin
        victim = rr_q[ridx];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[w][ridx]) victim = WAY_W'(w);
        rr_next = (rr_q[ridx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[ridx] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || bus.ext_flush) begin
            vld_p0   <= '0;
            vld_p1   <= '0;
            vld_p2   <= '0;
            miss_p2  <= '0;
            instr_p2 <= '0;
        end else if (!bus.ext_stall) begin
            vld_p0  <= int_stall ? '0 : bus.read_addr_valid;
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;
            miss_p2 <= miss_vec;
            for (int p = 0; p < NUM_READ; p++)
                instr_p2[p] <= (vld_p1[p] && hit_p1[p]) ? word_p1[p] : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!bus.ext_stall) begin
            for (int p = 0; p < NUM_READ; p++) begin
                addr_p0[p] <= bus.read_addr[p][ADDR_WIDTH-1:2];
                line_p1[p] <= addr_p0[p][WA_W-1:OFF_W];
            end
            hit_p1  <= hit_c;
            word_p1 <= word_c;
        end
    end

    // Refill / invalidate controller; a fence.i arriving mid-refill waits in inv_pend
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INVAL;
            sweep_cnt <= '0;
            inv_pend  <= 1'b0;
            req_line  <= '0;
            for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
        end else begin
            if (bus.invalidate_all && state != IDLE) inv_pend <= 1'b1;
            unique case (state)
                INVAL: begin
                    for (int w = 0; w < WAYS; w++) valid_q[w][sweep_cnt] <= 1'b0;
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == IDX_W'(NUM_SETS - 1)) state <= IDLE;
                end
                IDLE: begin
                    if (bus.invalidate_all || inv_pend) begin
                        state     <= INVAL;
                        sweep_cnt <= '0;
                        inv_pend  <= 1'b0;
                    end else if (miss_det) begin
                        state    <= REQ;
                        req_line <= miss_line;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) state <= bus.ext_flush ? DRAIN : WAIT;
                    else if (bus.ext_flush) state <= IDLE;
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        state     <= bus.ext_flush ? IDLE : FILL;
                        fill_data <= bus.mem_resp_data;
                    end else if (bus.ext_flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: if (bus.mem_resp_valid) state <= IDLE;
                FILL: begin
                    valid_q[victim][ridx] <= 1'b1;
                    tag_q[victim][ridx]   <= req_line[LINE_AW-1 -: TAG_W];
                    data_q[victim][ridx]  <= fill_data;
                    rr_q[ridx]            <= rr_next;
                    state                 <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
